// File: rtl/serial_adder.sv
// Bit-serial adder: one bit position per clock, LSB first. The result and the
// final carry are published together on entry to DONE.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             s_bit;
   logic             c_bit;
   logic [WIDTH-1:0] r_next;

   assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
   assign c_bit  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
   assign r_next = {s_bit, r_sh[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         r_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               r_sh  <= r_next;
               carry <= c_bit;
               cnt   <= cnt + CW'(1);
               // Last bit: publish straight from the adder so sum never shows partial bits
               if (cnt == LAST) begin
                  sum   <= r_next;
                  cout  <= c_bit;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed checks of serial_adder against an arithmetic model
// of a + b + cin, including cycle-by-cycle busy/done/sum timing.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] prev_sum;
   logic         prev_cout;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One operation, checked every cycle from the accepting edge to the return to IDLE.
   // With scramble set, operands change every cycle and start pulses mid-run.
   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic oc, input bit scramble);
      longint       total;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      int           nd;
      total    = longint'(oa) + longint'(ob) + longint'(oc);
      exp_sum  = W'(total % (longint'(1) << W));
      exp_cout = ((total >> W) & 1) != 0;
      nd       = 0;
      @(negedge clk);
      start = 1'b1; a = oa; b = ob; cin = oc;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         chk("busy", 64'(busy), 64'(i < W));
         chk("done", 64'(done), 64'(i == W));
         if (done) nd++;
         if (i < W) begin
            chk("sum_hold", 64'(sum), 64'(prev_sum));
            chk("cout_hold", 64'(cout), 64'(prev_cout));
         end else begin
            chk("sum", 64'(sum), 64'(exp_sum));
            chk("cout", 64'(cout), 64'(exp_cout));
         end
         if (scramble) begin
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            start = (i == 2);
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_count", 64'(nd), 64'(1));
      prev_sum  = exp_sum;
      prev_cout = exp_cout;
   endtask

   initial begin
      int last;
      int nd;
      int nb;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      prev_sum = '0; prev_cout = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_cout", 64'(cout), 64'(0));
      rst = 1'b0;

      run_op(8'd3, 8'd5, 1'b0, 1'b0);
      run_op(8'd255, 8'd1, 1'b0, 1'b0);
      run_op(8'hAA, 8'h55, 1'b1, 1'b0);
      run_op(8'h3C, 8'h41, 1'b1, 1'b1);
      run_op(8'hFF, 8'hFF, 1'b1, 1'b0);

      // start held high: results repeat every W+2 cycles
      @(negedge clk);
      a = 8'd1; b = 8'd1; cin = 1'b1; start = 1'b1;
      last = -1; nd = 0;
      for (int i = 0; i < 5 * (W + 2) + 2; i++) begin
         @(negedge clk);
         if (done) begin
            chk("b2b_sum", 64'(sum), 64'(3));
            chk("b2b_cout", 64'(cout), 64'(0));
            if (last >= 0) chk("b2b_period", 64'(i - last), 64'(W + 2));
            last = i;
            nd++;
         end
      end
      start = 1'b0;
      chk("b2b_count", 64'(nd), 64'(5));
      repeat (W + 2) @(negedge clk);
      prev_sum = 8'd3; prev_cout = 1'b0;

      // asynchronous reset in the middle of RUN
      start = 1'b1; a = 8'h77; b = 8'h19; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 64'(busy), 64'(1));
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_done", 64'(done), 64'(0));
      chk("arst_sum", 64'(sum), 64'(0));
      chk("arst_cout", 64'(cout), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      nd = 0; nb = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         if (done) nd++;
         if (busy) nb++;
      end
      chk("arst_no_done", 64'(nd), 64'(0));
      chk("arst_no_busy", 64'(nb), 64'(0));
      prev_sum = '0; prev_cout = 1'b0;

      run_op(8'h12, 8'h34, 1'b1, 1'b0);

      for (int n = 0; n < 200; n++)
         run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
